serial_slave_port: RTL
======================

// Module: serial_slave_port
// PURPOSE
//  Slave side of the serial system bus; sits downstream of master_port.
//  Deserialises address/mode/data frames from mwdata/mmode/mvalid and performs
//  the write or read on a local byte memory (mem). Read data returns serially on
//  srdata/svalid, which master_port samples as mrdata/svalid.
// PARAMETERS
//  ADDR_WIDTH      16  bus address width; frame carries all bits (min 2)
//  DATA_WIDTH      8   data word width (min 2)
//  MEM_ADDR_WIDTH  12  local memory index width; depth = 2**MEM_ADDR_WIDTH
// PORTS
//  clk     in   1           bus clock, all logic on posedge
//  rst     in   1           synchronous, active-high reset
//  mwdata  in   1           serial address/write-data bit from master, LSB first
//  mmode   in   1           0 read, 1 write; sampled on first address bit only
//  mvalid  in   1           high for every valid bit of a master frame
//  srdata  out  1           serial read-data bit to master, LSB first
//  svalid  out  1           high for each valid srdata bit
//  sbusy   out  1           high in any state other than IDLE
// BEHAVIOUR
//  Reset: state IDLE, bit counter 0, srdata=0, svalid=0, sbusy=0; addr/data
//  shift regs cleared; mem contents NOT reset. Reset wins over all events.
//  States: IDLE, ADDR, WDATA, MEMWR, MEMRD, RDATA.
//  IDLE: mvalid=1 -> shift mwdata into addr[0], latch mode=mmode, cnt=1 -> ADDR.
//  ADDR: each mvalid=1 cycle shifts bit into addr[cnt], cnt++; on cycle storing
//   bit ADDR_WIDTH-1: cnt=0, -> WDATA if mode=1 else MEMRD.
//  WDATA: each mvalid=1 cycle stores bit into wdata[cnt]; after bit DATA_WIDTH-1
//   -> MEMWR.
//  MEMWR (1 cycle): mem[addr[MEM_ADDR_WIDTH-1:0]] <= wdata; -> IDLE.
//  MEMRD (1 cycle): rbuf <= mem[addr[MEM_ADDR_WIDTH-1:0]]; cnt=0; -> RDATA.
//  RDATA: svalid=1, srdata=rbuf[cnt] (registered outputs), cnt++ each cycle;
//   after bit DATA_WIDTH-1 driven -> IDLE, svalid=0 next cycle.
//  Frame gaps: mvalid=0 in ADDR or WDATA aborts frame -> IDLE; no mem access.
//  mvalid ignored in MEMWR/MEMRD/RDATA; a frame may begin on the first IDLE cycle
//   (back-to-back frames, no idle gap required).
//  Upper address bits [ADDR_WIDTH-1:MEM_ADDR_WIDTH] ignored (aliasing).
//  Latency: write -- last data bit at cycle T, mem updated at end of T+1,
//   sbusy low at T+2. Read -- last addr bit at T, svalid high T+2..T+1+DATA_WIDTH.
//  srdata=0 whenever svalid=0.
// TESTING
//  1 Write 0xA5 to 0x0123 -> mem[0x123]=0xA5 two cycles after last bit, sbusy
//    drops at T+2, svalid never asserts.
//  2 Read 0x0123 after test 1 -> svalid high exactly 8 cycles from T+2, srdata
//    sequence 1,0,1,0,0,1,0,1; master_port drdata=0xA5.
//  3 Write 0x3C to 0xF123 -> mem[0x123]=0x3C (alias); read of 0x0123 returns 0x3C.
//  4 Drop mvalid after 7 address bits of write to 0x0456 -> IDLE next cycle,
//    mem[0x456] unchanged; following full frame decodes correctly.
//  5 Assert rst during RDATA bit 3 -> next cycle svalid=0, srdata=0, sbusy=0;
//    mem unchanged; new read frame then returns correct data.
//  6 10 random write/read pairs back-to-back, with mvalid toggled during RDATA
//    -> every readback matches written data; mvalid in RDATA has no effect.

Source files
------------

// File: rtl/serial_slave_port.sv
// serial_slave_port: deserialises master frames and serves writes/reads on a local byte memory
module serial_slave_port #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int MEM_ADDR_WIDTH = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic mwdata,
    input  logic mmode,
    input  logic mvalid,
    output logic srdata,
    output logic svalid,
    output logic sbusy
);
    localparam int CW = $clog2((ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH) + 1);
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, MEMWR, MEMRD, RDATA} state_t;
    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rbuf_q, rbuf_d;
    logic                    mode_q, mode_d;
    logic                    srdata_q, srdata_d;
    logic                    svalid_q, svalid_d;
    logic                    sbusy_q, sbusy_d;
    logic [DATA_WIDTH-1:0]   mem [2**MEM_ADDR_WIDTH];
    logic [DATA_WIDTH-1:0]   mem_rd;
    assign mem_rd = mem[addr_q[MEM_ADDR_WIDTH-1:0]];
    assign srdata = srdata_q;
    assign svalid = svalid_q;
    assign sbusy  = sbusy_q;
    // Address, write data and read buffer are right-shift registers: LSB-first bits land in place.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rbuf_d   = rbuf_q;
        mode_d   = mode_q;
        srdata_d = 1'b0;
        svalid_d = 1'b0;
        case (state_q)
            IDLE: if (mvalid) begin
                addr_d  = {mwdata, {(ADDR_WIDTH-1){1'b0}}};
                mode_d  = mmode;
                cnt_d   = CW'(1);
                state_d = ADDR;
            end
            ADDR: if (!mvalid) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                addr_d = {mwdata, addr_q[ADDR_WIDTH-1:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(ADDR_WIDTH-1)) begin
                    cnt_d   = '0;
                    state_d = mode_q ? WDATA : MEMRD;
                end
            end
            WDATA: if (!mvalid) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                wdata_d = {mwdata, wdata_q[DATA_WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_WIDTH-1)) begin
                    cnt_d   = '0;
                    state_d = MEMWR;
                end
            end
            MEMWR: state_d = IDLE;
            // Bit 0 goes straight to the output so svalid rises the cycle after MEMRD.
            MEMRD: begin
                rbuf_d   = mem_rd >> 1;
                srdata_d = mem_rd[0];
                svalid_d = 1'b1;
                cnt_d    = CW'(1);
                state_d  = RDATA;
            end
            RDATA: if (cnt_q == CW'(DATA_WIDTH)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                srdata_d = rbuf_q[0];
                svalid_d = 1'b1;
                rbuf_d   = rbuf_q >> 1;
                cnt_d    = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
        sbusy_d = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rbuf_q   <= '0;
            mode_q   <= 1'b0;
            srdata_q <= 1'b0;
            svalid_q <= 1'b0;
            sbusy_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rbuf_q   <= rbuf_d;
            mode_q   <= mode_d;
            srdata_q <= srdata_d;
            svalid_q <= svalid_d;
            sbusy_q  <= sbusy_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && state_q == MEMWR) mem[addr_q[MEM_ADDR_WIDTH-1:0]] <= wdata_q;
    end
endmodule
